adc_rx_packer: RTL and testbench
================================

ADC_RX_PACKER -- requirements
Module: adc_rx_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO depth in words (power of two, >=4).
REQ-002 SHALL have parameter CNT_W, default 16, width of the capture-length and drop counters.
REQ-003 SHALL have clk  input  1  ADC output clock after input buffer; the only clock; all logic on rising edge.
REQ-004 SHALL have resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have d_fall  input  8  lane bits from the falling-edge half-period, presented on a clk rising edge; lane k carries w[2k+1].
REQ-006 SHALL have d_rise  input  8  lane bits from the rising-edge half-period, presented on the same rising edge; lane k carries w[2k].
REQ-007 SHALL have start  input  1  single-cycle capture request.
REQ-008 SHALL have num_samples  input  CNT_W  capture length, sampled when start is accepted.
REQ-009 SHALL have m_tdata  output  16  assembled sample.
REQ-010 SHALL have m_tvalid, m_tready, m_tlast  output/input/output  1 each  AXI4-Stream handshake; tlast marks the final sample of a capture.
REQ-011 SHALL have busy  output  1  high in ARM, CAPTURE and DRAIN.
REQ-012 SHALL have done  output  1  one-cycle pulse when the tlast beat transfers.
REQ-013 SHALL have overflow  output  1  sticky, set when a sample is dropped.
REQ-014 SHALL have drop_cnt  output  CNT_W  count of dropped samples, saturating at all-ones.

Function
REQ-015 SHALL register d_fall/d_rise every cycle and assemble w[2k+1]=d_fall[k], w[2k]=d_rise[k], k=0..7.
REQ-016 SHALL implement FSM IDLE -> ARM -> CAPTURE -> DRAIN -> IDLE.
REQ-017 SHALL in IDLE accept start only if num_samples != 0; start with num_samples==0, or start outside IDLE, is ignored.
REQ-018 SHALL spend exactly one cycle in ARM; this aligns capture to the assembled-word pipeline, clears overflow and drop_cnt, and loads the remaining counter.
REQ-019 SHALL in CAPTURE write one assembled word per cycle into the FIFO, decrementing the remaining counter per cycle, written or dropped.
REQ-020 SHALL drop the word when the FIFO is full, except when a read transfer occurs in the same cycle; a drop sets overflow and increments drop_cnt.
REQ-021 SHALL tag the word of the final CAPTURE cycle with tlast; if that word is dropped, the last word actually written carries tlast instead.
REQ-022 SHALL move CAPTURE -> DRAIN after the final cycle, and DRAIN -> IDLE on the cycle the tlast beat transfers (m_tvalid & m_tready & m_tlast).
REQ-023 SHALL present the FIFO head first-word-fall-through: m_tvalid high whenever non-empty; m_tdata/m_tlast stable while m_tvalid & !m_tready.
REQ-024 SHALL allow simultaneous FIFO write and read in any cycle, including when full or empty.
REQ-025 SHALL give latency of 3 clk from the d_* edge to m_tvalid with an empty FIFO: input reg, assemble, FIFO.
REQ-026 SHALL pulse done on the tlast transfer cycle; busy falls the next cycle.

Reset
REQ-027 SHALL on resetn low immediately force IDLE, empty FIFO, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, overflow=0, drop_cnt=0; a capture in progress is abandoned with no tlast emitted.

Configuration
REQ-028 SHALL, with macro ADC_RX_TEST_PATTERN_EN defined, add input test_mode; when high, the assembled word is replaced by a 16-bit ramp starting at 0x0000 on ARM and wrapping 0xFFFF->0x0000; without the macro, no test_mode port and no ramp logic.

Verification
REQ-029 SHALL verify: d_fall=0xFF, d_rise=0x00, num_samples=4, m_tready=1 -> four beats 0xAAAA, last with tlast, one done pulse.
REQ-030 SHALL verify: ADC-model words 0x1234, 0x8001 serialized as DDR lanes -> m_tdata 0x1234 then 0x8001, bit order exact.
REQ-031 SHALL verify: num_samples=40, m_tready=0 -> 16 words held, overflow=1, drop_cnt=24, tlast on 16th word after m_tready=1.
REQ-032 SHALL verify: start with num_samples=0, and start during CAPTURE -> ignored, busy unchanged.
REQ-033 SHALL verify: resetn low mid-CAPTURE after 5 of 10 beats -> m_tvalid=0 and busy=0 immediately; next capture of 3 yields exactly 3 beats.
REQ-034 SHALL verify: ADC_RX_TEST_PATTERN_EN defined, test_mode=1, num_samples=3 -> 0x0000, 0x0001, 0x0002 with tlast.

Source files
------------

// File: rtl/adc_rx_packer.sv
// adc_rx_packer
//   Captures DDR ADC lane data, assembles 16-bit samples and buffers a
//   requested number of them in a first-word-fall-through FIFO. The FIFO
//   drains over an AXI4-Stream master port.
//
//   Optional feature: define ADC_RX_TEST_PATTERN_EN to add the test_mode
//   input. While test_mode is high, the assembled word is replaced by a
//   16-bit ramp that restarts at 0x0000 on every ARM.
//
// Parameters
//   FIFO_DEPTH  sample FIFO depth in words (power of two, >= 4)
//   CNT_W       width of num_samples and drop_cnt
// Ports
//   clk, resetn             ADC output clock; asynchronous active-low reset
//   d_fall, d_rise          lane bits; lane k carries w[2k+1] / w[2k]
//   start, num_samples      capture request and capture length
//   m_tdata/tvalid/tready/tlast   AXI4-Stream sample output
//   busy                    high while a capture is armed, running or draining
//   done                    one-cycle pulse when the tlast beat transfers
//   overflow, drop_cnt      sticky drop flag and saturating drop counter
//   test_mode               (ADC_RX_TEST_PATTERN_EN only) select the ramp pattern
module adc_rx_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       d_fall,
    input  logic [7:0]       d_rise,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
`ifdef ADC_RX_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic [15:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, rem_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic [7:0]        fall_q, rise_q;
    logic [15:0]       asm_w, word_q, wr_data;

    logic [15:0]            mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_q;
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]          wr_idx, rd_idx, prev_idx;
    logic                   empty, full, rd_en, wr_en, drop, cap, final_cyc;

    // Stage 1: input register; Stage 2: interleave lanes into the sample word
    always_comb begin
        asm_w = '0;
        for (int k = 0; k < 8; k++) begin
            asm_w[2*k+1] = fall_q[k];
            asm_w[2*k]   = rise_q[k];
        end
    end

    always_ff @(posedge clk) begin
        fall_q <= d_fall;
        rise_q <= d_rise;
        word_q <= asm_w;
    end

`ifdef ADC_RX_TEST_PATTERN_EN
    logic [15:0] ramp_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ramp_q <= '0;
        end else if (state_q == S_ARM) begin
            ramp_q <= '0;
        end else if (state_q == S_CAPTURE) begin
            ramp_q <= ramp_q + 16'd1;
        end
    end

    assign wr_data = test_mode ? ramp_q : word_q;
`else
    assign wr_data = word_q;
`endif

    // Stage 3: FIFO write / FWFT read
    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign prev_idx  = wr_idx - AW'(1);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign rd_en     = !empty && m_tready;
    assign cap       = (state_q == S_CAPTURE);
    assign final_cyc = cap && (rem_q == CNT_W'(1));
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    assign wr_en     = cap && (!full || rd_en);
    assign drop      = cap && full && !rd_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q       <= wr_ptr_q + (AW+1)'(1);
                last_q[wr_idx] <= final_cyc;
            end else if (drop && final_cyc) begin
                // Final word dropped: the newest stored word closes the capture.
                last_q[prev_idx] <= 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Gate on empty so stale storage never reaches the port.
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? 16'h0000 : mem_q[rd_idx];
    assign m_tlast  = !empty && last_q[rd_idx];
    assign done     = rd_en && m_tlast;
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start && (num_samples != '0)) state_d = S_ARM;
            S_ARM:     state_d = S_CAPTURE;
            S_CAPTURE: if (final_cyc) state_d = S_DRAIN;
            S_DRAIN:   if (done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            rem_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                len_q <= num_samples;
            end
            if (state_q == S_ARM) begin
                rem_q      <= len_q;
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else begin
                if (cap) begin
                    rem_q <= rem_q - CNT_W'(1);
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_rx_packer.sv
module tb_adc_rx_packer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic [7:0]       d_fall, d_rise;
    logic             start;
    logic [CNT_W-1:0] num_samples;
`ifdef ADC_RX_TEST_PATTERN_EN
    logic             test_mode;
`endif
    logic [15:0]      m_tdata;
    logic             m_tvalid, m_tready, m_tlast;
    logic             busy, done, overflow;
    logic [CNT_W-1:0] drop_cnt;

    adc_rx_packer #(.FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .d_fall     (d_fall),
        .d_rise     (d_rise),
        .start      (start),
        .num_samples(num_samples),
`ifdef ADC_RX_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int done_cnt = 0;
    logic [16:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: a beat is committed on the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (resetn && m_tvalid && m_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got tlast=%0b data=0x%0h expected no beat", m_tlast, m_tdata);
            end else begin
                chk("beat", {15'd0, m_tlast, m_tdata}, {15'd0, exp_q.pop_front()});
            end
        end
        if (resetn && done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [15:0] w);
        for (int k = 0; k < 8; k++) begin
            d_fall[k] = w[2*k+1];
            d_rise[k] = w[2*k];
        end
    endtask

    task automatic push_run(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n-1), w});
    endtask

    task automatic start_cap(input int n);
        start = 1'b1;
        num_samples = CNT_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle with 0 pending", nm, busy, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    int d0, b0;

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        num_samples = '0;
        m_tready = 1'b1;
        d_fall = '0;
        d_rise = '0;
`ifdef ADC_RX_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        step(); step();
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        resetn = 1'b1;
        step();

        // 1: constant lanes, fall=1 rise=0 -> 0xAAAA x4
        d0 = done_cnt;
        d_fall = 8'hFF;
        d_rise = 8'h00;
        push_run(16'hAAAA, 4);
        start_cap(4);
        wait_idle(40, "t1");
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 2: bit order and latency
        exp_q.push_back({1'b0, 16'h1234});
        exp_q.push_back({1'b1, 16'h8001});
        set_word(16'h1234);
        start_cap(2);
        set_word(16'h8001);
        step();
        chk("t2_lat_early", 32'(m_tvalid), 32'd0);
        step();
        chk("t2_lat_valid", 32'(m_tvalid), 32'd1);
        set_word(16'h0000);
        wait_idle(40, "t2");

        // 3: overflow with stalled sink
        m_tready = 1'b0;
        set_word(16'h5A3C);
        push_run(16'h5A3C, 16);
        start_cap(40);
        for (int i = 0; i < 50; i++) step();
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd24);
        chk("t3_held_valid", 32'(m_tvalid), 32'd1);
        chk("t3_held_data", 32'(m_tdata), 32'h5A3C);
        chk("t3_busy_drain", 32'(busy), 32'd1);
        m_tready = 1'b1;
        wait_idle(60, "t3");

        // 4: ignored starts
        start_cap(0);
        step(); step();
        chk("t4_zero_len_busy", 32'(busy), 32'd0);
        d0 = done_cnt;
        b0 = beats;
        set_word(16'h0F0F);
        push_run(16'h0F0F, 3);
        start_cap(3);
        step();
        start_cap(5);
        chk("t4_busy_in_cap", 32'(busy), 32'd1);
        wait_idle(40, "t4");
        step(); step();
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_beats", 32'(beats - b0), 32'd3);
        chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        chk("t4_drop_cleared", 32'(drop_cnt), 32'd0);

        // 5: reset mid-capture
        b0 = beats;
        set_word(16'h1111);
        push_run(16'h1111, 10);
        start_cap(10);
        for (int i = 0; i < 40 && (beats - b0) < 5; i++) @(negedge clk);
        chk("t5_five_beats", 32'(beats - b0), 32'd5);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        step(); step();
        resetn = 1'b1;
        step();
        b0 = beats;
        d0 = done_cnt;
        set_word(16'hC3A5);
        push_run(16'hC3A5, 3);
        start_cap(3);
        wait_idle(40, "t5");
        step(); step();
        chk("t5_beats", 32'(beats - b0), 32'd3);
        chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);

`ifdef ADC_RX_TEST_PATTERN_EN
        // 6: ramp pattern
        test_mode = 1'b1;
        set_word(16'hFFFF);
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b0, 16'h0001});
        exp_q.push_back({1'b1, 16'h0002});
        start_cap(3);
        wait_idle(40, "t6");
        test_mode = 1'b0;
`endif

        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
